// File: rtl/uart_pkg.sv
// Shared FSM state type, oversampling constants and baud-divisor helper
// for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_state_t;

   localparam int OVS        = 16;
   localparam int SAMPLE_LO  = 7;
   localparam int SAMPLE_MID = 8;
   localparam int SAMPLE_HI  = 9;
   localparam int DATA_BITS  = 8;

   // Rounded clk_freq / (uart_freq * OVS).
   function automatic int calc_div(input int clk_freq, input int uart_freq);
      return (clk_freq + uart_freq * (OVS / 2)) / (uart_freq * OVS);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, re-phased by
// a synchronous restart so the first tick lands DIV cycles after it.
module uart_baud_tick #(
   parameter logic [15:0] DIV = 16'd72
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   logic [15:0] r_cnt;

   assign tick = (r_cnt == DIV - 16'd1);

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         r_cnt <= 16'd0;
      end else if (tick) begin
         r_cnt <= 16'd0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampling with 3-sample majority vote and
// av/en pop interface. Define UART_RX_PARITY_EN for an 8E1 frame.
module uart_rx
   import uart_pkg::*;
#(
   parameter int clk_freq  = 133333000,
   parameter int uart_freq = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxp,
   output logic [7:0] rx_data,
   output logic       rx_av,
   input  logic       rx_en,
   output logic       rx_frame_err,
   output logic       rx_ovr,
   output logic       rx_par_err
);

   localparam int         DIV      = calc_div(clk_freq, uart_freq);
   localparam logic [3:0] POS_LO   = 4'(SAMPLE_LO);
   localparam logic [3:0] POS_MID  = 4'(SAMPLE_MID);
   localparam logic [3:0] POS_HI   = 4'(SAMPLE_HI);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam uart_state_t ST_AFTER_DATA = ST_PARITY;
`else
   localparam uart_state_t ST_AFTER_DATA = ST_STOP;
`endif

   logic        r_sync1;
   logic        r_sync2;
   logic        r_prev;
   uart_state_t r_state;
   logic [3:0]  r_os_cnt;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic        r_s_lo;
   logic        r_s_mid;
   logic [7:0]  r_data;
   logic        r_av;
   logic        r_frame_err;
   logic        r_ovr;
`ifdef UART_RX_PARITY_EN
   logic        r_par_err;
   logic        r_par_bad;
`endif

   logic        w_rx;
   logic        w_tick;
   logic        w_start_edge;
   logic [3:0]  w_pos;
   logic        w_decide;
   logic        w_vote;
   logic        w_par_ok;

   assign w_rx         = r_sync2;
   assign w_start_edge = (r_state == ST_IDLE) && r_prev && !w_rx;
   assign w_pos        = r_os_cnt + 4'd1;
   assign w_decide     = w_tick && (w_pos == POS_HI);
   assign w_vote       = (r_s_lo & r_s_mid) | (r_s_lo & w_rx) | (r_s_mid & w_rx);

`ifdef UART_RX_PARITY_EN
   assign w_par_ok   = !r_par_bad;
   assign rx_par_err = r_par_err;
`else
   assign w_par_ok   = 1'b1;
   assign rx_par_err = 1'b0;
`endif

   assign rx_data      = r_data;
   assign rx_av        = r_av;
   assign rx_frame_err = r_frame_err;
   assign rx_ovr       = r_ovr;

   uart_baud_tick #(
      .DIV (16'(DIV))
   ) u_baud_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (w_start_edge),
      .tick    (w_tick)
   );

   // Presetting to 1 keeps reset release from looking like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= rxp;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_os_cnt    <= 4'd0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_s_lo      <= 1'b1;
         r_s_mid     <= 1'b1;
         r_data      <= 8'h00;
         r_av        <= 1'b0;
         r_frame_err <= 1'b0;
         r_ovr       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err   <= 1'b0;
         r_par_bad   <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
         r_ovr       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_err   <= 1'b0;
`endif
         // A delivery later in this block overrides the pop.
         if (r_av && rx_en) begin
            r_av <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_start_edge) begin
                  r_os_cnt  <= 4'd0;
                  r_bit_cnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
                  r_par_bad <= 1'b0;
`endif
                  r_state   <= ST_START;
               end
            end
            ST_BREAK: begin
               if (w_rx) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               if (w_tick) begin
                  r_os_cnt <= w_pos;
                  if (w_pos == POS_LO) begin
                     r_s_lo <= w_rx;
                  end
                  if (w_pos == POS_MID) begin
                     r_s_mid <= w_rx;
                  end
               end
               if (w_decide) begin
                  case (r_state)
                     ST_START: begin
                        r_state <= w_vote ? ST_IDLE : ST_DATA;
                     end
                     ST_DATA: begin
                        r_shift   <= {w_vote, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == LAST_BIT) begin
                           r_state <= ST_AFTER_DATA;
                        end
                     end
`ifdef UART_RX_PARITY_EN
                     ST_PARITY: begin
                        if ((^r_shift) ^ w_vote) begin
                           r_par_bad <= 1'b1;
                           r_par_err <= 1'b1;
                        end
                        r_state <= ST_STOP;
                     end
`endif
                     ST_STOP: begin
                        if (w_vote) begin
                           if (w_par_ok) begin
                              if (!r_av || rx_en) begin
                                 r_data <= r_shift;
                                 r_av   <= 1'b1;
                              end else begin
                                 r_ovr <= 1'b1;
                              end
                           end
                           r_state <= ST_IDLE;
                        end else begin
                           r_frame_err <= 1'b1;
                           r_state     <= ST_BREAK;
                        end
                     end
                     default: begin
                        r_state <= ST_IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 460800 baud (DIV=18, 288 cycles/bit) to keep runs short.
// Define UART_RX_PARITY_EN to exercise the 8E1 frame.
`timescale 1ns/1ps
module tb_uart_rx;

   // DIV = (133333000 + 460800*8) / (460800*16) = 18; stop decision at tick
   // 153 plus 3 cycles of synchroniser/edge/restart latency.
   localparam int BIT_CYC = 288;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int EXP_LAT = 153 * 18 + 3 + PAR_EN * BIT_CYC;

   typedef struct {
      logic [7:0] data;
      logic       par_ok;
      logic       stop;
      int         low_hold;
      logic       deliver;
      int         frames;
      int         pars;
   } vec_t;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       rxp   = 1'b1;
   logic       rx_en = 1'b0;
   logic [7:0] rx_data;
   logic       rx_av;
   logic       rx_frame_err;
   logic       rx_ovr;
   logic       rx_par_err;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int start_cyc = 0;
   int n_frame = 0;
   int n_ovr = 0;
   int n_par = 0;
   int got_cnt = 0;
   logic [7:0] got_data [64];
   int         got_lat  [64];
   logic       prev_av = 1'b0;
   logic [7:0] exp_q [$];
   vec_t       vecs [$];

   uart_rx #(
      .clk_freq  (133333000),
      .uart_freq (460800)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rxp          (rxp),
      .rx_data      (rx_data),
      .rx_av        (rx_av),
      .rx_en        (rx_en),
      .rx_frame_err (rx_frame_err),
      .rx_ovr       (rx_ovr),
      .rx_par_err   (rx_par_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: counts pulse cycles and captures each rx_av rising edge.
   always @(negedge clk) begin
      if (rx_frame_err) n_frame++;
      if (rx_ovr) n_ovr++;
      if (rx_par_err) n_par++;
      if (rx_av && !prev_av && got_cnt < 64) begin
         got_data[got_cnt] = rx_data;
         got_lat[got_cnt]  = cyc - start_cyc;
         got_cnt++;
      end
      prev_av = rx_av;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic check_lat(input string name, input int lat);
      n_vec++;
      if (lat < EXP_LAT - 2 || lat > EXP_LAT + 2) begin
         n_bad++;
         $display("FAIL %s: got %0d cycles, expected %0d +/-2", name, lat, EXP_LAT);
      end else begin
         $display("ok   %s = %0d cycles", name, lat);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop,
                             input int low_hold);
      logic [10:0] bits;
      int          nb;
      bits      = '0;
      bits[8:1] = d;
      nb        = 9;
      if (PAR_EN != 0) begin
         bits[9] = par_ok ? ^d : ~^d;
         nb      = 10;
      end
      bits[nb] = stop;
      nb++;
      @(posedge clk);
      #1 rxp = bits[0];
      start_cyc = cyc;
      for (int i = 1; i < nb; i++) begin
         repeat (BIT_CYC) @(posedge clk);
         #1 rxp = bits[i];
      end
      repeat (BIT_CYC) @(posedge clk);
      if (!stop) repeat (low_hold) @(posedge clk);
      #1 rxp = 1'b1;
   endtask

   task automatic do_pop(input string tag);
      @(posedge clk);
      #1 rx_en = 1'b1;
      @(posedge clk);
      #1 rx_en = 1'b0;
      @(negedge clk);
      check({tag, "_av_after_pop"}, int'(rx_av), 0);
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int g0, f0, p0, o0;
      logic [7:0] exp_b;
      g0 = got_cnt; f0 = n_frame; p0 = n_par; o0 = n_ovr;
      if (v.deliver) exp_q.push_back(v.data);
      send_frame(v.data, v.par_ok, v.stop, v.low_hold);
      repeat (600) @(posedge clk);
      @(negedge clk);
      check({tag, "_deliveries"}, got_cnt - g0, v.deliver ? 1 : 0);
      check({tag, "_frame_err"}, n_frame - f0, v.frames);
      check({tag, "_par_err"}, n_par - p0, v.pars);
      check({tag, "_ovr"}, n_ovr - o0, 0);
      if (v.deliver) begin
         exp_b = exp_q.pop_front();
         if (got_cnt > g0) begin
            check({tag, "_data"}, int'(got_data[g0]), int'(exp_b));
            check_lat({tag, "_latency"}, got_lat[g0]);
         end
         check({tag, "_av_level"}, int'(rx_av), 1);
      end else begin
         check({tag, "_av_level"}, int'(rx_av), 0);
      end
      if (rx_av) do_pop(tag);
   endtask

   initial begin
      int g0, f0, p0, o0;
      logic [7:0] exp_b;

      vecs.push_back('{8'hA5, 1'b1, 1'b1, 0,    1'b1, 0, 0});
      vecs.push_back('{8'h55, 1'b1, 1'b1, 0,    1'b1, 0, 0});
      vecs.push_back('{8'h3C, 1'b1, 1'b0, 1500, 1'b0, 1, 0});
      vecs.push_back('{8'h55, 1'b1, 1'b1, 0,    1'b1, 0, 0});
      vecs.push_back('{8'h00, 1'b1, 1'b1, 0,    1'b1, 0, 0});
      vecs.push_back('{8'hFF, 1'b1, 1'b1, 0,    1'b1, 0, 0});
      vecs.push_back('{8'h81, 1'b1, 1'b1, 0,    1'b1, 0, 0});
`ifdef UART_RX_PARITY_EN
      vecs.push_back('{8'h07, 1'b0, 1'b1, 0,    1'b0, 0, 1});
      vecs.push_back('{8'h07, 1'b1, 1'b1, 0,    1'b1, 0, 0});
`endif

      // Reset state and quiet idle line.
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_av", int'(rx_av), 0);
      check("reset_data", int'(rx_data), 0);
      check("reset_pulses", int'({rx_frame_err, rx_ovr, rx_par_err}), 0);
      repeat (20000) @(posedge clk);
      @(negedge clk);
      check("idle_deliveries", got_cnt, 0);
      check("idle_pulses", n_frame + n_ovr + n_par, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         run_frame(vecs[i], $sformatf("vec%0d", i));
      end

      // Short low glitch (well under half a bit) must be ignored.
      g0 = got_cnt; f0 = n_frame; p0 = n_par;
      @(posedge clk);
      #1 rxp = 1'b0;
      repeat (80) @(posedge clk);
      #1 rxp = 1'b1;
      repeat (3000) @(posedge clk);
      @(negedge clk);
      check("glitch_deliveries", got_cnt - g0, 0);
      check("glitch_pulses", (n_frame - f0) + (n_par - p0), 0);
      run_frame('{8'h55, 1'b1, 1'b1, 0, 1'b1, 0, 0}, "post_glitch");

      // Overrun: second byte dropped while the first is still held.
      g0 = got_cnt; o0 = n_ovr;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b1, 0);
      send_frame(8'h22, 1'b1, 1'b1, 0);
      repeat (600) @(posedge clk);
      @(negedge clk);
      check("ovr_deliveries", got_cnt - g0, 1);
      check("ovr_pulses", n_ovr - o0, 1);
      exp_b = exp_q.pop_front();
      check("ovr_held_data", int'(rx_data), int'(exp_b));
      if (got_cnt > g0) check("ovr_first_data", int'(got_data[g0]), int'(exp_b));
      do_pop("ovr");

      // Pop in the very cycle of the second delivery: no overrun.
      g0 = got_cnt; o0 = n_ovr;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b1, 0);
      exp_q.push_back(8'h22);
      fork
         send_frame(8'h22, 1'b1, 1'b1, 0);
         begin
            @(posedge clk);
            #1;
            repeat (EXP_LAT - 1) @(posedge clk);
            #1 rx_en = 1'b1;
            @(posedge clk);
            #1 rx_en = 1'b0;
         end
      join
      repeat (600) @(posedge clk);
      @(negedge clk);
      check("popdel_ovr", n_ovr - o0, 0);
      exp_b = exp_q.pop_front();
      if (got_cnt > g0) check("popdel_first_data", int'(got_data[g0]), int'(exp_b));
      exp_b = exp_q.pop_front();
      check("popdel_data", int'(rx_data), int'(exp_b));
      check("popdel_av", int'(rx_av), 1);
      do_pop("popdel");

      // Reset mid-frame: frame aborted, no flags, data cleared.
      g0 = got_cnt; f0 = n_frame; p0 = n_par; o0 = n_ovr;
      @(posedge clk);
      #1 rxp = 1'b0;
      repeat (BIT_CYC * 3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) @(posedge clk);
      #1 rxp = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_data", int'(rx_data), 0);
      repeat (4000) @(posedge clk);
      @(negedge clk);
      check("midrst_deliveries", got_cnt - g0, 0);
      check("midrst_pulses", (n_frame - f0) + (n_par - p0) + (n_ovr - o0), 0);
      run_frame('{8'hC3, 1'b1, 1'b1, 0, 1'b1, 0, 0}, "post_rst");

      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
